// File: rtl/cordic_req_arbiter.sv
// Round-robin front end sharing one pipelined CORDIC engine among N_REQ requesters.
// Optional stall watchdog is enabled by defining CORDIC_ARB_WDOG_EN.
module cordic_req_arbiter #(
    parameter int                    DATA_WIDTH   = 18,
    parameter int                    N_REQ        = 4,
    parameter int                    MAX_INFLIGHT = 16,
    parameter logic [DATA_WIDTH-1:0] X_INIT       = 18'h026de,
    parameter int                    WDOG_CYCLES  = 64
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic [N_REQ-1:0]                      i_req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]           i_req_angle,
    output logic [N_REQ-1:0]                      o_req_ready,
    output logic [DATA_WIDTH-1:0]                 o_cordic_x,
    output logic [DATA_WIDTH-1:0]                 o_cordic_y,
    output logic [DATA_WIDTH-1:0]                 o_cordic_alpha,
    output logic                                  o_cordic_valid,
    input  logic [DATA_WIDTH-1:0]                 i_cordic_cos,
    input  logic [DATA_WIDTH-1:0]                 i_cordic_sin,
    input  logic                                  i_cordic_valid,
    output logic [N_REQ-1:0]                      o_rsp_valid,
    output logic [DATA_WIDTH-1:0]                 o_rsp_cos,
    output logic [DATA_WIDTH-1:0]                 o_rsp_sin,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]     o_inflight,
    output logic                                  o_err_spurious,
    output logic                                  o_wdog_err
);
    localparam int TW = $clog2(N_REQ);
    localparam int PW = $clog2(MAX_INFLIGHT);
    localparam int CW = $clog2(MAX_INFLIGHT+1);
    localparam logic [TW:0]   NREQ_W = (TW+1)'(N_REQ);
    localparam logic [TW-1:0] LAST   = TW'(N_REQ-1);
    localparam logic [CW-1:0] FULL   = CW'(MAX_INFLIGHT);

    logic [DATA_WIDTH-1:0] angle [N_REQ];
    logic [TW-1:0]         rr_ptr;
    logic [TW-1:0]         grant_idx;
    logic [TW:0]           cand;
    logic                  found;
    logic                  can_grant;
    logic                  push, pop, spurious;
    logic                  wdog_fire;
    logic [TW-1:0]         tag_mem [MAX_INFLIGHT];
    logic [PW-1:0]         wr_ptr, rd_ptr;

    for (genvar r = 0; r < N_REQ; r++) begin : g_unpack
        assign angle[r] = i_req_angle[r*DATA_WIDTH +: DATA_WIDTH];
    end

    // Ready uses the registered count, so a pop while full does not free a slot this cycle.
    assign can_grant = i_rst_n && (o_inflight < FULL);

    always_comb begin
        o_req_ready = '0;
        grant_idx   = '0;
        cand        = '0;
        found       = 1'b0;
        if (can_grant) begin
            for (int i = 0; i < N_REQ; i++) begin
                cand = {1'b0, rr_ptr} + (TW+1)'(i);
                if (cand >= NREQ_W) cand = cand - NREQ_W;
                if (!found && i_req_valid[cand[TW-1:0]]) begin
                    found     = 1'b1;
                    grant_idx = cand[TW-1:0];
                end
            end
        end
        o_req_ready[grant_idx] = found;
    end

    assign push     = found;
    assign pop      = i_cordic_valid && (o_inflight != '0);
    assign spurious = i_cordic_valid && (o_inflight == '0);

    always_ff @(posedge i_clk) begin
        if (push) tag_mem[wr_ptr] <= grant_idx;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rr_ptr         <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            o_inflight     <= '0;
            o_cordic_valid <= 1'b0;
            o_cordic_x     <= '0;
            o_cordic_y     <= '0;
            o_cordic_alpha <= '0;
            o_rsp_valid    <= '0;
            o_rsp_cos      <= '0;
            o_rsp_sin      <= '0;
            o_err_spurious <= 1'b0;
        end else begin
            o_cordic_valid <= push;
            if (push) begin
                o_cordic_alpha <= angle[grant_idx];
                o_cordic_x     <= X_INIT;
                o_cordic_y     <= '0;
                rr_ptr         <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
                wr_ptr         <= wr_ptr + 1'b1;
            end

            o_rsp_valid <= '0;
            if (pop) begin
                o_rsp_valid[tag_mem[rd_ptr]] <= 1'b1;
                o_rsp_cos <= i_cordic_cos;
                o_rsp_sin <= i_cordic_sin;
                rd_ptr    <= rd_ptr + 1'b1;
            end
            o_err_spurious <= spurious;

            case ({push, pop})
                2'b10:   o_inflight <= o_inflight + 1'b1;
                2'b01:   o_inflight <= o_inflight - 1'b1;
                default: o_inflight <= o_inflight;
            endcase

            // Flush keeps only a tag pushed in the same cycle (a pop cannot coincide).
            if (wdog_fire) begin
                rd_ptr     <= wr_ptr;
                o_inflight <= push ? CW'(1) : '0;
            end
        end
    end

`ifdef CORDIC_ARB_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES+1);
    logic [WW-1:0] wdog_cnt;

    assign wdog_fire = (o_inflight != '0) && !i_cordic_valid &&
                       (wdog_cnt == WW'(WDOG_CYCLES-1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wdog_cnt   <= '0;
            o_wdog_err <= 1'b0;
        end else begin
            o_wdog_err <= wdog_fire;
            if (wdog_fire || i_cordic_valid || o_inflight == '0) wdog_cnt <= '0;
            else                                                 wdog_cnt <= wdog_cnt + 1'b1;
        end
    end
`else
    assign wdog_fire  = 1'b0;
    assign o_wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Directed bench for cordic_req_arbiter with a 16-cycle delay-line engine model.
module tb_cordic_req_arbiter;
    localparam int DW = 18;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [NR*DW-1:0] req_angle;
    logic [NR-1:0] req_ready;
    logic [DW-1:0] cordic_x, cordic_y, cordic_alpha;
    logic          cordic_valid;
    logic [DW-1:0] eng_cos, eng_sin;
    logic          eng_valid;
    logic [NR-1:0] rsp_valid;
    logic [DW-1:0] rsp_cos, rsp_sin;
    logic [4:0]    inflight;
    logic          err_spurious, wdog_err;

    logic          eng_en, eng_clr, inj_v;
    logic [DW-1:0] inj_cos, inj_sin;
    logic [15:0]   pv;
    logic [DW-1:0] pc [16];
    logic [DW-1:0] ps [16];

    int chk = 0;
    int pass = 0;

    always #5 clk = ~clk;

    cordic_req_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_angle(req_angle), .o_req_ready(req_ready),
        .o_cordic_x(cordic_x), .o_cordic_y(cordic_y), .o_cordic_alpha(cordic_alpha),
        .o_cordic_valid(cordic_valid),
        .i_cordic_cos(eng_cos), .i_cordic_sin(eng_sin), .i_cordic_valid(eng_valid),
        .o_rsp_valid(rsp_valid), .o_rsp_cos(rsp_cos), .o_rsp_sin(rsp_sin),
        .o_inflight(inflight), .o_err_spurious(err_spurious), .o_wdog_err(wdog_err)
    );

    // Engine stand-in: cos = alpha ^ 15555, sin = alpha + 1, 16 cycles later.
    always @(posedge clk) begin
        if (eng_clr) begin
            pv <= '0;
        end else begin
            pv <= {pv[14:0], cordic_valid};
        end
        pc[0] <= cordic_alpha ^ 18'h15555;
        ps[0] <= cordic_alpha + 18'd1;
        for (int k = 1; k < 16; k++) begin
            pc[k] <= pc[k-1];
            ps[k] <= ps[k-1];
        end
    end

    assign eng_valid = (eng_en & pv[15]) | inj_v;
    assign eng_cos   = inj_v ? inj_cos : pc[15];
    assign eng_sin   = inj_v ? inj_sin : ps[15];

    task automatic do_reset();
        @(negedge clk);
        req_valid = '0;
        inj_v     = 1'b0;
        rst_n     = 1'b0;
        eng_clr   = 1'b1;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        eng_clr = 1'b0;
        eng_en  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; eng_clr = 1'b1; eng_en = 1'b1; inj_v = 1'b0;
        inj_cos = '0; inj_sin = '0;
        req_valid = 4'b1111;
        req_angle = {18'h04444, 18'h03333, 18'h02222, 18'h01111};
        repeat (3) @(negedge clk);
        #1;
        chk++; if (req_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", req_ready); else pass++;
        chk++; if (cordic_valid !== 1'b0) $display("FAIL reset_cvalid got %b want 0", cordic_valid); else pass++;
        chk++; if (cordic_x !== 18'h0) $display("FAIL reset_x got %h want 0", cordic_x); else pass++;
        chk++; if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp got %b want 0000", rsp_valid); else pass++;
        chk++; if (inflight !== 5'd0) $display("FAIL reset_inflight got %0d want 0", inflight); else pass++;
        chk++; if ({err_spurious, wdog_err} !== 2'b00) $display("FAIL reset_err got %b want 00", {err_spurious, wdog_err}); else pass++;
        req_valid = '0;
        rst_n = 1'b1; eng_clr = 1'b0;
    endtask

    task automatic test_single();
        bit got;
        do_reset();
        req_angle[DW-1:0] = 18'h0C90F;
        req_valid = 4'b0001;
        #1;
        chk++; if (req_ready !== 4'b0001) $display("FAIL single_ready got %b want 0001", req_ready); else pass++;
        @(negedge clk);
        req_valid = '0;
        #1;
        chk++; if (cordic_valid !== 1'b1) $display("FAIL single_cvalid got %b want 1", cordic_valid); else pass++;
        chk++; if (cordic_alpha !== 18'h0C90F) $display("FAIL single_alpha got %h want 0c90f", cordic_alpha); else pass++;
        chk++; if (cordic_x !== 18'h026DE) $display("FAIL single_x got %h want 026de", cordic_x); else pass++;
        chk++; if (cordic_y !== 18'h0) $display("FAIL single_y got %h want 0", cordic_y); else pass++;
        chk++; if (inflight !== 5'd1) $display("FAIL single_inflight got %0d want 1", inflight); else pass++;
        @(negedge clk); #1;
        chk++; if (cordic_valid !== 1'b0) $display("FAIL single_pulse got %b want 0", cordic_valid); else pass++;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk); #1;
            if (rsp_valid != '0) got = 1'b1;
        end
        chk++; if (!got) $display("FAIL single_rsp_timeout got none want response"); else pass++;
        chk++; if (rsp_valid !== 4'b0001) $display("FAIL single_rsp_valid got %b want 0001", rsp_valid); else pass++;
        chk++; if (rsp_cos !== 18'h19C5A) $display("FAIL single_cos got %h want 19c5a", rsp_cos); else pass++;
        chk++; if (rsp_sin !== 18'h0C910) $display("FAIL single_sin got %h want 0c910", rsp_sin); else pass++;
        chk++; if (inflight !== 5'd0) $display("FAIL single_drain got %0d want 0", inflight); else pass++;
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] expv;
        logic [DW-1:0] ang [4];
        int n;
        ang[0] = 18'h01111; ang[1] = 18'h02222; ang[2] = 18'h03333; ang[3] = 18'h04444;
        do_reset();
        req_angle = {ang[3], ang[2], ang[1], ang[0]};
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            expv = 4'b0001 << (c % 4);
            chk++; if (req_ready !== expv) $display("FAIL rr_grant%0d got %b want %b", c, req_ready, expv); else pass++;
            @(negedge clk);
        end
        req_valid = '0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (rsp_valid != '0) begin
                expv = 4'b0001 << (n % 4);
                chk++; if (rsp_valid !== expv) $display("FAIL rr_rsp%0d got %b want %b", n, rsp_valid, expv); else pass++;
                chk++; if (rsp_cos !== (ang[n % 4] ^ 18'h15555)) $display("FAIL rr_cos%0d got %h want %h", n, rsp_cos, ang[n % 4] ^ 18'h15555); else pass++;
                n++;
            end
            @(negedge clk);
        end
        chk++; if (n != 8) $display("FAIL rr_count got %0d want 8", n); else pass++;
    endtask

    task automatic test_full_stall();
        int n;
        do_reset();
        eng_en = 1'b0;
        req_valid = 4'b0010;
        n = 0;
        for (int i = 0; i < 24; i++) begin
            #1;
            if (req_ready[1]) n++;
            @(negedge clk);
        end
        #1;
        chk++; if (n != 16) $display("FAIL full_accepts got %0d want 16", n); else pass++;
        chk++; if (req_ready !== 4'b0000) $display("FAIL full_ready got %b want 0000", req_ready); else pass++;
        chk++; if (inflight !== 5'd16) $display("FAIL full_inflight got %0d want 16", inflight); else pass++;
        inj_cos = 18'h00AAA; inj_sin = 18'h00555; inj_v = 1'b1;
        #1;
        chk++; if (req_ready !== 4'b0000) $display("FAIL full_pop_ready got %b want 0000", req_ready); else pass++;
        @(negedge clk);
        inj_v = 1'b0;
        #1;
        chk++; if (inflight !== 5'd15) $display("FAIL full_after_pop got %0d want 15", inflight); else pass++;
        chk++; if (rsp_valid !== 4'b0010) $display("FAIL full_rsp got %b want 0010", rsp_valid); else pass++;
        chk++; if (rsp_cos !== 18'h00AAA) $display("FAIL full_rsp_cos got %h want 00aaa", rsp_cos); else pass++;
        chk++; if (req_ready !== 4'b0010) $display("FAIL full_regrant got %b want 0010", req_ready); else pass++;
        @(negedge clk); #1;
        chk++; if (inflight !== 5'd16) $display("FAIL full_refill got %0d want 16", inflight); else pass++;
        chk++; if (req_ready !== 4'b0000) $display("FAIL full_reblock got %b want 0000", req_ready); else pass++;
        req_valid = '0;
    endtask

    task automatic test_spurious();
        do_reset();
        inj_cos = 18'h01234; inj_sin = 18'h04321; inj_v = 1'b1;
        @(negedge clk);
        inj_v = 1'b0;
        #1;
        chk++; if (err_spurious !== 1'b1) $display("FAIL spur_pulse got %b want 1", err_spurious); else pass++;
        chk++; if (rsp_valid !== 4'b0000) $display("FAIL spur_rsp got %b want 0000", rsp_valid); else pass++;
        chk++; if (inflight !== 5'd0) $display("FAIL spur_inflight got %0d want 0", inflight); else pass++;
        @(negedge clk); #1;
        chk++; if (err_spurious !== 1'b0) $display("FAIL spur_width got %b want 0", err_spurious); else pass++;
    endtask

    task automatic test_reset_inflight();
        int n, bad;
        do_reset();
        req_angle = {18'h04444, 18'h03333, 18'h02222, 18'h01111};
        req_valid = 4'b0100;
        repeat (5) @(negedge clk);
        req_valid = '0;
        #1;
        chk++; if (inflight !== 5'd5) $display("FAIL rst5_pre got %0d want 5", inflight); else pass++;
        rst_n = 1'b0;
        req_valid = 4'b0100;
        @(negedge clk); #1;
        chk++; if (inflight !== 5'd0) $display("FAIL rst5_inflight got %0d want 0", inflight); else pass++;
        chk++; if (req_ready !== 4'b0000) $display("FAIL rst5_ready got %b want 0000", req_ready); else pass++;
        chk++; if ({cordic_valid, cordic_alpha, cordic_x} !== '0) $display("FAIL rst5_issue got %b/%h/%h want 0", cordic_valid, cordic_alpha, cordic_x); else pass++;
        chk++; if ({rsp_valid, rsp_cos} !== '0) $display("FAIL rst5_rsp got %b/%h want 0", rsp_valid, rsp_cos); else pass++;
        req_valid = '0;
        rst_n = 1'b1;
        n = 0; bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (err_spurious) n++;
            if (rsp_valid != '0) bad++;
        end
        chk++; if (n != 5) $display("FAIL rst5_spurious got %0d want 5", n); else pass++;
        chk++; if (bad != 0) $display("FAIL rst5_no_rsp got %0d want 0", bad); else pass++;
        chk++; if (inflight !== 5'd0) $display("FAIL rst5_final got %0d want 0", inflight); else pass++;
    endtask

`ifdef CORDIC_ARB_WDOG_EN
    task automatic test_wdog();
        bit got;
        do_reset();
        eng_en = 1'b0;
        req_valid = 4'b0001;
        repeat (3) @(negedge clk);
        req_valid = '0;
        #1;
        chk++; if (inflight !== 5'd3) $display("FAIL wdog_pre got %0d want 3", inflight); else pass++;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk); #1;
            if (wdog_err) got = 1'b1;
        end
        chk++; if (!got) $display("FAIL wdog_timeout got none want pulse"); else pass++;
        chk++; if (inflight !== 5'd0) $display("FAIL wdog_flush got %0d want 0", inflight); else pass++;
        req_valid = 4'b0001;
        #1;
        chk++; if (req_ready !== 4'b0001) $display("FAIL wdog_resume got %b want 0001", req_ready); else pass++;
        @(negedge clk);
        req_valid = '0;
        #1;
        chk++; if (wdog_err !== 1'b0) $display("FAIL wdog_width got %b want 0", wdog_err); else pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_spurious();
        test_reset_inflight();
`ifdef CORDIC_ARB_WDOG_EN
        test_wdog();
`endif
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
